// File: rtl/demux_dispatch_ctrl.sv
// Stream dispatcher for a 1-to-N demux with one registered output beat.
// Round-robin over enabled channels, or a fixed channel in fixed mode.
module demux_dispatch_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [N_OUT-1:0]  ch_en,
    input  logic              fix_mode,
    input  logic [SEL_W-1:0]  fix_sel,
    output logic [N_OUT-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [SEL_W-1:0]  cur_sel,
    output logic [CNT_W-1:0]  sent_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_tgt;
    logic             rr_ok;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] target;
    logic             tgt_ok;
    logic             deliver;
    logic             accept;

    // Round-robin search: the smallest offset from rr_ptr with an enabled channel wins.
    always_comb begin
        rr_tgt = '0;
        rr_ok  = 1'b0;
        idx    = '0;
        for (int k = N_OUT - 1; k >= 0; k--) begin
            idx = rr_ptr + SEL_W'(k);
            if (ch_en[idx]) begin
                rr_tgt = idx;
                rr_ok  = 1'b1;
            end
        end
    end

    // Target selection between fixed and round-robin modes.
    always_comb begin
        target = rr_tgt;
        tgt_ok = rr_ok;
        if (fix_mode) begin
            target = fix_sel;
            tgt_ok = ch_en[fix_sel];
        end
    end

    assign deliver = (state_q == BUSY) & out_ready[cur_sel];
    assign accept  = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: load on accept, empty on deliver unless refilled in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (deliver && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-hot valid from the held channel; ready blocked while in reset.
    always_comb begin
        out_valid = '0;
        if (state_q == BUSY) out_valid = N_OUT'(1) << cur_sel;
        in_ready = ~rst & tgt_ok & ((state_q == IDLE) | deliver);
    end

    // Held beat, its channel and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            cur_sel  <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            out_data <= in_data;
            cur_sel  <= target;
            if (!fix_mode) rr_ptr <= target + SEL_W'(1);
        end
    end

    // Delivered-beat counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          sent_cnt <= '0;
        else if (deliver) sent_cnt <= sent_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl with a scoreboard of
// expected (channel, data) pairs popped on each observed delivery.
module tb_demux_dispatch_ctrl;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  ch_en;
    logic        fix_mode;
    logic [1:0]  fix_sel;
    logic [3:0]  out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_ready;
    logic [1:0]  cur_sel;
    logic [15:0] sent_cnt;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    demux_dispatch_ctrl #(.DATA_W(8), .N_OUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ch_en(ch_en), .fix_mode(fix_mode), .fix_sel(fix_sel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cur_sel(cur_sel), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge: a delivery pops and checks the scoreboard head.
    task automatic monitor();
        exp_t e;
        if ((out_valid & out_ready) != 4'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_delivery observed=%0h expected=none", out_valid);
            end else begin
                e = sb.pop_front();
                chk("dlv_ch", 32'(out_valid), 32'(4'b0001 << e.ch));
                chk("dlv_data", 32'(out_data), 32'(e.d));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat for a cycle; it must be accepted and land on channel ch.
    task automatic beat(input logic [7:0] d, input logic [1:0] ch);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        e.ch = ch;
        e.d  = d;
        sb.push_back(e);
        @(negedge clk);
        chk("beat_in_ready", 32'(in_ready), 32'd1);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        ch_en     = 4'hF;
        fix_mode  = 1'b0;
        fix_sel   = 2'd0;
        out_ready = 4'hF;

        // T1 reset with a valid producer
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        step();

        // T2 round-robin streaming, first beat proves rr_ptr starts at 0
        for (int i = 0; i < 8; i++) beat(8'(8'h10 + i), 2'(i % 4));
        in_valid = 1'b0;
        step();
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_sent_cnt", 32'(sent_cnt), 32'd8);
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_hold_data", 32'(out_data), 32'h17);

        // T3 disabled channels skipped
        ch_en = 4'b1010;
        beat(8'h20, 2'd1);
        beat(8'h21, 2'd3);
        beat(8'h22, 2'd1);
        beat(8'h23, 2'd3);
        in_valid = 1'b0;
        step();
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_sent_cnt", 32'(sent_cnt), 32'd12);

        // T4 backpressure on channel 0, other ready bits ignored
        ch_en     = 4'hF;
        out_ready = 4'b1110;
        beat(8'hA5, 2'd0);
        in_data = 8'h77;
        repeat (5) begin
            @(negedge clk);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_out_valid", 32'(out_valid), 32'b0001);
            chk("t4_out_data", 32'(out_data), 32'hA5);
            chk("t4_cur_sel", 32'(cur_sel), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        chk("t4_cnt_held", 32'(sent_cnt), 32'd12);
        out_ready = 4'hF;
        beat(8'h77, 2'd1);
        in_valid = 1'b0;
        chk("t4_cnt_plus1", 32'(sent_cnt), 32'd13);
        step();
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_sent_cnt", 32'(sent_cnt), 32'd14);

        // T5 fixed mode to channel 2
        fix_mode = 1'b1;
        fix_sel  = 2'd2;
        beat(8'h30, 2'd2);
        beat(8'h31, 2'd2);
        beat(8'h32, 2'd2);
        in_valid = 1'b0;
        step();
        chk("t5_sent_cnt", 32'(sent_cnt), 32'd17);
        ch_en    = 4'b1011;
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (2) begin
            @(negedge clk);
            chk("t5_blocked", 32'(in_ready), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("t5_no_accept", 32'(out_valid), 32'd0);
        // back to round-robin: pointer still 2 from the last rr beat
        fix_mode = 1'b0;
        ch_en    = 4'hF;
        beat(8'h99, 2'd2);
        in_valid = 1'b0;
        step();
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        chk("t5_sent_cnt2", 32'(sent_cnt), 32'd18);

        // T6 no enabled channel
        ch_en    = 4'h0;
        in_valid = 1'b1;
        in_data  = 8'h44;
        repeat (2) begin
            @(negedge clk);
            chk("t6_none_ready", 32'(in_ready), 32'd0);
            monitor();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("t6_none_idle", 32'(out_valid), 32'd0);

        // T6 reset while busy discards the held beat
        ch_en     = 4'hF;
        out_ready = 4'h0;
        beat(8'hEE, 2'd3);
        in_valid = 1'b0;
        void'(sb.pop_front());
        chk("t6_busy", 32'(out_valid), 32'b1000);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_cnt", 32'(sent_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 4'hF;
        step();
        step();
        chk("t6_discarded", 32'(out_valid), 32'd0);

        // T6 counter wrap after 2^16 deliveries
        for (int i = 0; i < 65536; i++) beat(8'(i), 2'(i % 4));
        in_valid = 1'b0;
        chk("t6_cnt_max", 32'(sent_cnt), 32'hFFFF);
        step();
        chk("t6_wrap_sb", 32'(sb.size()), 32'd0);
        chk("t6_cnt_wrap", 32'(sent_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
